bias_bank_stream: RTL
=====================

// Module: bias_bank_stream
// PURPOSE
//  Runtime-loadable bias bank replacing per-layer hardwired bias constants. Holds N_GROUPS groups of
//  N_adder_tree signed W-bit biases, loaded serially from the weight stream, and returns one full
//  group (one bias per adder-tree lane) per accepted read. It sits between the parameter loader and
//  the adder-tree output stage of every conv layer.
// PARAMETERS
//  N_adder_tree  16  lanes per group (bias values presented in parallel on q)
//  W             18  bias width, two's complement, same fixed-point format as the adder-tree output
//  N_GROUPS      8   groups stored (output-channel groups per layer); any value >= 1
//  GW            $clog2(N_GROUPS) or 1 if N_GROUPS==1 (localparam)
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous, active-low reset
//  ld_start   in   1               begin (re)load; clears write pointers
//  ld_valid   in   1               ld_data valid
//  ld_ready   out  1               bank accepts ld_data (high only in LOAD)
//  ld_data    in   W               one bias per beat; lane-major within group, group 0 first
//  loaded     out  1               bank fully loaded, reads allowed
//  rd_req     in   1               read request for group rd_grp
//  rd_grp     in   GW              group index
//  rd_ready   in   1               downstream accepts q
//  q_valid    out  1               q holds a returned group
//  q          out  N_adder_tree*W  lane i at q[W*(i+1)-1:W*i]
//  rd_err     out  1               sticky: read refused (not loaded) or rd_grp >= N_GROUPS
//  acc_in     in   N_adder_tree*W  (BIAS_ADD_EN only) accumulator lanes, sampled with rd_req
// BEHAVIOUR
//  Reset: state=IDLE, ld_ready=0, loaded=0, q_valid=0, q=0, rd_err=0, bank contents=0, pointers=0.
//  FSM: IDLE -ld_start-> LOAD; LOAD -last beat accepted-> READY; READY -ld_start-> LOAD.
//   ld_start in any state: next cycle state=LOAD, lane/group pointers=0, loaded=0, q_valid=0 (flush).
//  LOAD: beat accepted when ld_valid&&ld_ready; writes bank[grp][lane]; lane wraps at N_adder_tree-1
//   and increments grp; beat with grp=N_GROUPS-1, lane=N_adder_tree-1 -> READY, loaded=1 next cycle.
//   ld_ready=0 in the cycle after the last beat (no extra beat is ever written).
//  READY read: rd_req accepted when !q_valid || rd_ready (output slot free or draining).
//   Latency 1: cycle after acceptance q_valid=1, q=bank[rd_grp]. Back-to-back reads give one group
//   per cycle while rd_ready=1. q_valid && !rd_ready: q and q_valid hold, rd_req not accepted.
//   Handshake completes on q_valid&&rd_ready; q_valid drops unless a new read was accepted.
//  Errors: rd_req in IDLE/LOAD, or rd_grp>=N_GROUPS -> no q_valid, rd_err=1 until reset or ld_start.
//  Priority in one cycle: ld_start > rd_req. ld_valid outside LOAD is ignored.
//  Reset mid-load: bank cleared, loaded=0; a full reload is required.
// CONFIGURATION
//  BIAS_ADD_EN defined: acc_in port present; q lane i = sat_W(acc_in[i] + bias[i]) computed at W+1
//   bits, clamped to [-2^(W-1), 2^(W-1)-1]; acc_in sampled in the accepting cycle; latency still 1.
//  BIAS_ADD_EN undefined: no acc_in port; q lanes are raw bias values.
// STRUCTURE
//  Package bias_pkg: BIAS_W=18, state enum {IDLE,LOAD,READY}, BIAS_MAX/BIAS_MIN saturation constants.
//  Sub-module bias_sat_add (one per lane, generate loop, instantiated only under BIAS_ADD_EN):
//   combinational W+W -> W saturating adder.
// TESTING
//  1 Reset, ld_start, 128 beats (defaults) of value = 18'h00100+idx, stall ld_valid every 3rd cycle
//    -> loaded=1 after beat 128; beat 129 not accepted (ld_ready=0).
//  2 Reads grp 0..7 back-to-back, rd_ready=1 -> q_valid every cycle, lane i of grp g = 18'h00100+16g+i.
//  3 rd_ready=0 for 4 cycles with q_valid=1 -> q stable, further rd_req not accepted, no lost group.
//  4 rd_req before loaded, and (N_GROUPS=6 build) rd_grp=7 -> no q_valid, rd_err=1, cleared by ld_start.
//  5 ld_start same cycle as rd_req in READY, and rst_n low mid-load -> LOAD entered, q_valid=0;
//    after reset every lane reads 0 once reloaded with zeros.
//  6 BIAS_ADD_EN: bias 18'h1FFFF + acc 18'h00010 -> 18'h1FFFF; bias 18'h20000 + acc 18'h3FFFF
//    -> 18'h20000; bias 18'h00534 + acc 18'h3FFFC -> 18'h00530.

Source files
------------

// File: rtl/bias_pkg.sv
// Shared types and constants for the bias bank: bias width, FSM states, saturation limits.
package bias_pkg;
   localparam int BIAS_W = 18;
   localparam logic signed [BIAS_W-1:0] BIAS_MAX = {1'b0, {(BIAS_W-1){1'b1}}};
   localparam logic signed [BIAS_W-1:0] BIAS_MIN = {1'b1, {(BIAS_W-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
endpackage

// File: rtl/bias_sat_add.sv
// Combinational W+W -> W two's-complement saturating adder (one adder-tree lane).
module bias_sat_add import bias_pkg::*; #(
   parameter int W = BIAS_W
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y
);
   localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

   logic signed [W:0] sum;

   always_comb begin
      sum = {a[W-1], a} + {b[W-1], b};
      // top two bits disagree only when the W-bit result overflowed
      if (sum[W] != sum[W-1]) y = sum[W] ? MINV : MAXV;
      else                    y = sum[W-1:0];
   end
endmodule

// File: rtl/bias_bank_stream.sv
// Serially loaded bias bank returning one group of N_adder_tree biases per accepted read.
// Optional BIAS_ADD_EN: adds acc_in lanes to the biases with saturation before presenting q.
module bias_bank_stream import bias_pkg::*; #(
   parameter  int N_adder_tree = 16,
   parameter  int W            = BIAS_W,
   parameter  int N_GROUPS     = 8,
   localparam int GW           = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ld_start,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [W-1:0]              ld_data,
   output logic                      loaded,
   input  logic                      rd_req,
   input  logic [GW-1:0]             rd_grp,
   input  logic                      rd_ready,
   output logic                      q_valid,
   output logic [N_adder_tree*W-1:0] q,
   output logic                      rd_err
`ifdef BIAS_ADD_EN
   ,
   input  logic [N_adder_tree*W-1:0] acc_in
`endif
);
   localparam int LW = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;

   state_t state, state_nxt;
   logic [LW-1:0] lane_ptr;
   logic [GW-1:0] grp_ptr, rd_idx;
   logic [N_GROUPS-1:0][N_adder_tree-1:0][W-1:0] bank;
   logic [N_adder_tree-1:0][W-1:0] bank_rd, q_nxt;
   logic beat, last_beat, grp_ok, rd_ok, rd_bad;

   always_comb begin
      state_nxt = state;
      ld_ready  = (state == LOAD);
      beat      = ld_valid && ld_ready && !ld_start;
      last_beat = beat && (grp_ptr == GW'(N_GROUPS-1)) && (lane_ptr == LW'(N_adder_tree-1));
      grp_ok    = int'(rd_grp) < N_GROUPS;
      // ld_start pre-empts any read issued in the same cycle
      rd_ok     = rd_req && !ld_start && (state == READY) && grp_ok && (!q_valid || rd_ready);
      rd_bad    = rd_req && !ld_start && ((state != READY) || !grp_ok);
      case (state)
         LOAD:    if (last_beat) state_nxt = READY;
         default: state_nxt = state;
      endcase
      if (ld_start) state_nxt = LOAD;
   end

   assign rd_idx  = grp_ok ? rd_grp : '0;
   assign bank_rd = bank[rd_idx];

`ifdef BIAS_ADD_EN
   for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      bias_sat_add #(.W(W)) u_add (
         .a (acc_in[W*i +: W]),
         .b (bank_rd[i]),
         .y (q_nxt[i])
      );
   end
`else
   assign q_nxt = bank_rd;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lane_ptr <= '0;
         grp_ptr  <= '0;
         bank     <= '0;
         loaded   <= 1'b0;
         q_valid  <= 1'b0;
         q        <= '0;
         rd_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ld_start) begin
            lane_ptr <= '0;
            grp_ptr  <= '0;
            loaded   <= 1'b0;
         end else if (beat) begin
            bank[grp_ptr][lane_ptr] <= ld_data;
            if (lane_ptr == LW'(N_adder_tree-1)) begin
               lane_ptr <= '0;
               grp_ptr  <= grp_ptr + 1'b1;
            end else begin
               lane_ptr <= lane_ptr + 1'b1;
            end
            if (last_beat) loaded <= 1'b1;
         end

         if (ld_start)      q_valid <= 1'b0;
         else if (rd_ok)    q_valid <= 1'b1;
         else if (rd_ready) q_valid <= 1'b0;
         if (rd_ok) q <= q_nxt;

         if (ld_start)    rd_err <= 1'b0;
         else if (rd_bad) rd_err <= 1'b1;
      end
   end
endmodule
